intc_nmi_gen: RTL and testbench



---
 rtl/intc_nmi_pkg.sv | 15 +
 rtl/intc_nmi_gen_ch.sv | 131 +++++++++++++
 rtl/intc_nmi_gen.sv | 38 +++
 tb/tb_intc_nmi_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/intc_nmi_pkg.sv
// Shared types and default parameters for the per-CPU NMI issuer.
package intc_nmi_pkg;

    // Per-channel issue state
    typedef enum logic [1:0] {
        NMI_IDLE     = 2'd0,
        NMI_ASSERT   = 2'd1,
        NMI_WAIT_ACK = 2'd2
    } nmi_gen_st_t;

    localparam int NMI_CPU_NUM_DEF     = 4;
    localparam int NMI_PULSE_LEN_DEF   = 2;
    localparam int NMI_TIMEOUT_CYC_DEF = 1024;

endpackage : intc_nmi_pkg

// File: rtl/intc_nmi_gen_ch.sv
// One NMI channel: issues a fixed-width pulse, waits for the CPU acknowledge
// with an optional timeout, and queues one request that arrives while busy.
module intc_nmi_gen_ch
    import intc_nmi_pkg::*;
#(
    parameter int PULSE_LEN   = NMI_PULSE_LEN_DEF,
    parameter int TIMEOUT_CYC = NMI_TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_i,
    input  logic ack_i,
    input  logic clr_err_i,
    output logic nmi_o,
    output logic busy_o,
    output logic pend_o,
    output logic err_o
);

    localparam int PW = $clog2(PULSE_LEN + 1);
    // A disabled timeout still needs a legal one-bit counter
    localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC != 0);

    nmi_gen_st_t   state_r;
    nmi_gen_st_t   state_nxt_s;
    logic [PW-1:0] pcnt_r;
    logic [PW-1:0] pcnt_nxt_s;
    logic [TW-1:0] tcnt_r;
    logic [TW-1:0] tcnt_nxt_s;
    logic          ack_seen_r;
    logic          ack_seen_nxt_s;
    logic          pend_r;
    logic          pend_nxt_s;
    logic          err_r;
    logic          err_nxt_s;
    logic          err_set_s;
    logic          nmi_r;
    logic          busy_r;

    // Next-state, counter, pending and error logic for the channel FSM
    always_comb begin
        state_nxt_s    = state_r;
        pcnt_nxt_s     = pcnt_r;
        tcnt_nxt_s     = tcnt_r;
        ack_seen_nxt_s = ack_seen_r;
        pend_nxt_s     = pend_r;
        err_set_s      = 1'b0;

        case (state_r)
            NMI_IDLE: begin
                // Leaving IDLE consumes the queued request; staying means none was queued
                pend_nxt_s = 1'b0;
                if (req_i || pend_r) begin
                    state_nxt_s    = NMI_ASSERT;
                    pcnt_nxt_s     = PW'(PULSE_LEN);
                    ack_seen_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = NMI_IDLE;
                end
            end
            NMI_ASSERT: begin
                pend_nxt_s = pend_r | req_i;
                if (pcnt_r <= PW'(1)) begin
                    // Last high cycle: an ack seen at any point of the pulse skips WAIT_ACK
                    pcnt_nxt_s     = {PW{1'b0}};
                    ack_seen_nxt_s = 1'b0;
                    if (ack_seen_r || ack_i) begin
                        state_nxt_s = NMI_IDLE;
                    end else begin
                        state_nxt_s = NMI_WAIT_ACK;
                        tcnt_nxt_s  = {TW{1'b0}};
                    end
                end else begin
                    pcnt_nxt_s     = pcnt_r - PW'(1);
                    ack_seen_nxt_s = ack_seen_r | ack_i;
                end
            end
            NMI_WAIT_ACK: begin
                pend_nxt_s = pend_r | req_i;
                if (ack_i) begin
                    // Ack has priority over a coincident timeout
                    state_nxt_s = NMI_IDLE;
                end else if (TIMEOUT_EN && (tcnt_r == TW'(TIMEOUT_CYC - 1))) begin
                    state_nxt_s = NMI_IDLE;
                    err_set_s   = 1'b1;
                end else if (tcnt_r != {TW{1'b1}}) begin
                    tcnt_nxt_s = tcnt_r + TW'(1);
                end else begin
                    tcnt_nxt_s = tcnt_r;
                end
            end
            default: begin
                state_nxt_s = NMI_IDLE;
                pend_nxt_s  = 1'b0;
            end
        endcase

        // Sticky error: a new timeout beats a simultaneous clear
        err_nxt_s = err_set_s | (err_r & ~clr_err_i);
    end

    // Channel state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= NMI_IDLE;
            pcnt_r     <= {PW{1'b0}};
            tcnt_r     <= {TW{1'b0}};
            ack_seen_r <= 1'b0;
            pend_r     <= 1'b0;
            err_r      <= 1'b0;
            nmi_r      <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pcnt_r     <= pcnt_nxt_s;
            tcnt_r     <= tcnt_nxt_s;
            ack_seen_r <= ack_seen_nxt_s;
            pend_r     <= pend_nxt_s;
            err_r      <= err_nxt_s;
            nmi_r      <= (state_nxt_s == NMI_ASSERT);
            busy_r     <= (state_nxt_s != NMI_IDLE) | pend_nxt_s;
        end
    end

    assign nmi_o  = nmi_r;
    assign busy_o = busy_r;
    assign pend_o = pend_r;
    assign err_o  = err_r;

endmodule : intc_nmi_gen_ch

// File: rtl/intc_nmi_gen.sv
// Per-CPU NMI issuer: fans the mask write out to independent channels.
module intc_nmi_gen
    import intc_nmi_pkg::*;
#(
    parameter int CPU_NUM     = NMI_CPU_NUM_DEF,
    parameter int PULSE_LEN   = NMI_PULSE_LEN_DEF,
    parameter int TIMEOUT_CYC = NMI_TIMEOUT_CYC_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [CPU_NUM-1:0] wr_mask_i,
    input  logic [CPU_NUM-1:0] cp_intack_nmi_i,
    input  logic [CPU_NUM-1:0] clr_err_i,
    output logic [CPU_NUM-1:0] intreq_nmi_o,
    output logic [CPU_NUM-1:0] busy_o,
    output logic [CPU_NUM-1:0] pend_o,
    output logic [CPU_NUM-1:0] err_o
);

    for (genvar g = 0; g < CPU_NUM; g++) begin : g_ch
        intc_nmi_gen_ch #(
            .PULSE_LEN   (PULSE_LEN),
            .TIMEOUT_CYC (TIMEOUT_CYC)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .req_i     (wr_en_i & wr_mask_i[g]),
            .ack_i     (cp_intack_nmi_i[g]),
            .clr_err_i (clr_err_i[g]),
            .nmi_o     (intreq_nmi_o[g]),
            .busy_o    (busy_o[g]),
            .pend_o    (pend_o[g]),
            .err_o     (err_o[g])
        );
    end

endmodule : intc_nmi_gen

// File: tb/tb_intc_nmi_gen.sv
// Directed bench for intc_nmi_gen: one instance with PULSE_LEN=2, one with PULSE_LEN=4.
module tb_intc_nmi_gen;

    logic       clk;
    logic       rst_n;
    logic       wr_en;
    logic [3:0] wr_mask;
    logic [3:0] ack;
    logic [3:0] clr;
    logic [3:0] nmi;
    logic [3:0] busy;
    logic [3:0] pend;
    logic [3:0] err;

    logic       wr_en4;
    logic [3:0] wr_mask4;
    logic [3:0] ack4;
    logic [3:0] clr4;
    logic [3:0] nmi4;
    logic [3:0] busy4;
    logic [3:0] pend4;
    logic [3:0] err4;

    int n_cmp;
    int n_bad;

    intc_nmi_gen #(.CPU_NUM(4), .PULSE_LEN(2), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .wr_mask_i(wr_mask),
        .cp_intack_nmi_i(ack), .clr_err_i(clr), .intreq_nmi_o(nmi),
        .busy_o(busy), .pend_o(pend), .err_o(err)
    );

    intc_nmi_gen #(.CPU_NUM(4), .PULSE_LEN(4), .TIMEOUT_CYC(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en4), .wr_mask_i(wr_mask4),
        .cp_intack_nmi_i(ack4), .clr_err_i(clr4), .intreq_nmi_o(nmi4),
        .busy_o(busy4), .pend_o(pend4), .err_o(err4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL rst_nmi got=%b exp=%b", nmi, 4'b0000); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL rst_busy got=%b exp=%b", busy, 4'b0000); end
        n_cmp++; if (pend !== 4'b0000) begin n_bad++; $display("FAIL rst_pend got=%b exp=%b", pend, 4'b0000); end
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL rst_err got=%b exp=%b", err, 4'b0000); end
        n_cmp++; if (nmi4 !== 4'b0000) begin n_bad++; $display("FAIL rst_nmi4 got=%b exp=%b", nmi4, 4'b0000); end
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_single;
        // cycle 10: write CPU0
        wr_en = 1'b1; wr_mask = 4'b0001;
        tick(1); // cycle 11
        wr_en = 1'b0; wr_mask = 4'b0000;
        n_cmp++; if (nmi !== 4'b0001) begin n_bad++; $display("FAIL single_c11_nmi got=%b exp=%b", nmi, 4'b0001); end
        n_cmp++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL single_c11_busy got=%b exp=%b", busy, 4'b0001); end
        tick(1); // cycle 12
        n_cmp++; if (nmi !== 4'b0001) begin n_bad++; $display("FAIL single_c12_nmi got=%b exp=%b", nmi, 4'b0001); end
        tick(1); // cycle 13
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL single_c13_nmi got=%b exp=%b", nmi, 4'b0000); end
        n_cmp++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL single_c13_busy got=%b exp=%b", busy, 4'b0001); end
        tick(2); // cycle 15: ack
        ack = 4'b0001;
        n_cmp++; if (busy !== 4'b0001) begin n_bad++; $display("FAIL single_c15_busy got=%b exp=%b", busy, 4'b0001); end
        tick(1); // cycle 16
        ack = 4'b0000;
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL single_c16_busy got=%b exp=%b", busy, 4'b0000); end
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL single_c16_err got=%b exp=%b", err, 4'b0000); end
        tick(2);
    endtask

    task automatic test_timeout;
        wr_en = 1'b1; wr_mask = 4'b0010;
        tick(1); // c+1
        wr_en = 1'b0; wr_mask = 4'b0000;
        n_cmp++; if (nmi !== 4'b0010) begin n_bad++; $display("FAIL to_pulse got=%b exp=%b", nmi, 4'b0010); end
        tick(2); // c+3: first WAIT_ACK cycle
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL to_low got=%b exp=%b", nmi, 4'b0000); end
        tick(7); // c+10: eighth WAIT_ACK cycle
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL to_early_err got=%b exp=%b", err, 4'b0000); end
        n_cmp++; if (busy !== 4'b0010) begin n_bad++; $display("FAIL to_early_busy got=%b exp=%b", busy, 4'b0010); end
        tick(1); // c+11
        n_cmp++; if (err !== 4'b0010) begin n_bad++; $display("FAIL to_err got=%b exp=%b", err, 4'b0010); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL to_busy got=%b exp=%b", busy, 4'b0000); end
        clr = 4'b0010;
        tick(1);
        clr = 4'b0000;
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL to_clr got=%b exp=%b", err, 4'b0000); end
        // second timeout with a clear on the very same cycle
        wr_en = 1'b1; wr_mask = 4'b0010;
        tick(1); // d+1
        wr_en = 1'b0; wr_mask = 4'b0000;
        tick(9); // d+10: timeout cycle
        clr = 4'b0010;
        tick(1); // d+11
        clr = 4'b0000;
        n_cmp++; if (err !== 4'b0010) begin n_bad++; $display("FAIL to_set_wins got=%b exp=%b", err, 4'b0010); end
        clr = 4'b0010;
        tick(1);
        clr = 4'b0000;
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL to_clr2 got=%b exp=%b", err, 4'b0000); end
        tick(2);
    endtask

    task automatic test_back_to_back;
        int rises;
        logic prev;
        wr_en = 1'b1; wr_mask = 4'b0100;
        tick(1); // c+1: ASSERT, write again
        n_cmp++; if (nmi !== 4'b0100) begin n_bad++; $display("FAIL b2b_p1 got=%b exp=%b", nmi, 4'b0100); end
        tick(1); // c+2: ASSERT last cycle, write again
        n_cmp++; if (pend !== 4'b0100) begin n_bad++; $display("FAIL b2b_pend got=%b exp=%b", pend, 4'b0100); end
        tick(1); // c+3: WAIT_ACK, write again
        tick(1); // c+4: ack
        wr_en = 1'b0; wr_mask = 4'b0000;
        ack = 4'b0100;
        tick(1); // c+5: IDLE, low cycle
        ack = 4'b0000;
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL b2b_gap got=%b exp=%b", nmi, 4'b0000); end
        n_cmp++; if (pend !== 4'b0100) begin n_bad++; $display("FAIL b2b_pend_idle got=%b exp=%b", pend, 4'b0100); end
        n_cmp++; if (busy !== 4'b0100) begin n_bad++; $display("FAIL b2b_busy_idle got=%b exp=%b", busy, 4'b0100); end
        tick(1); // c+6: second pulse
        n_cmp++; if (nmi !== 4'b0100) begin n_bad++; $display("FAIL b2b_p2 got=%b exp=%b", nmi, 4'b0100); end
        n_cmp++; if (pend !== 4'b0000) begin n_bad++; $display("FAIL b2b_pend_clr got=%b exp=%b", pend, 4'b0000); end
        tick(2); // c+8: WAIT_ACK of second pulse
        ack = 4'b0100;
        tick(1);
        ack = 4'b0000;
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL b2b_done got=%b exp=%b", busy, 4'b0000); end
        // no third pulse may follow
        rises = 0;
        prev = nmi[2];
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (nmi[2] && !prev) rises++;
            prev = nmi[2];
        end
        n_cmp++; if (rises !== 0) begin n_bad++; $display("FAIL b2b_extra got=%0d exp=%0d", rises, 0); end
    endtask

    task automatic test_early_ack;
        wr_en4 = 1'b1; wr_mask4 = 4'b0001;
        tick(1); // ASSERT cycle 1, ack now
        wr_en4 = 1'b0; wr_mask4 = 4'b0000;
        ack4 = 4'b0001;
        n_cmp++; if (nmi4 !== 4'b0001) begin n_bad++; $display("FAIL early_c1 got=%b exp=%b", nmi4, 4'b0001); end
        tick(1);
        ack4 = 4'b0000;
        n_cmp++; if (nmi4 !== 4'b0001) begin n_bad++; $display("FAIL early_c2 got=%b exp=%b", nmi4, 4'b0001); end
        tick(2); // ASSERT cycle 4
        n_cmp++; if (nmi4 !== 4'b0001) begin n_bad++; $display("FAIL early_c4 got=%b exp=%b", nmi4, 4'b0001); end
        tick(1);
        n_cmp++; if (nmi4 !== 4'b0000) begin n_bad++; $display("FAIL early_low got=%b exp=%b", nmi4, 4'b0000); end
        n_cmp++; if (busy4 !== 4'b0000) begin n_bad++; $display("FAIL early_idle got=%b exp=%b", busy4, 4'b0000); end
        tick(10);
        n_cmp++; if (err4 !== 4'b0000) begin n_bad++; $display("FAIL early_err got=%b exp=%b", err4, 4'b0000); end
    endtask

    task automatic test_all_cpus;
        wr_en = 1'b1; wr_mask = 4'b1111;
        tick(1); // c+1
        wr_en = 1'b0; wr_mask = 4'b0000;
        n_cmp++; if (nmi !== 4'b1111) begin n_bad++; $display("FAIL all_rise got=%b exp=%b", nmi, 4'b1111); end
        n_cmp++; if (busy !== 4'b1111) begin n_bad++; $display("FAIL all_busy got=%b exp=%b", busy, 4'b1111); end
        tick(2); // c+3: WAIT_ACK
        ack = 4'b1001;
        tick(1); // c+4
        ack = 4'b0000;
        n_cmp++; if (busy !== 4'b0110) begin n_bad++; $display("FAIL all_partial got=%b exp=%b", busy, 4'b0110); end
        tick(7); // c+11
        n_cmp++; if (err !== 4'b0110) begin n_bad++; $display("FAIL all_err got=%b exp=%b", err, 4'b0110); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL all_idle got=%b exp=%b", busy, 4'b0000); end
        tick(1);
    endtask

    task automatic test_async_reset;
        wr_en = 1'b1; wr_mask = 4'b0001;
        tick(1); // c+1: ASSERT, second write queues
        tick(1); // c+2: mid-pulse
        wr_en = 1'b0; wr_mask = 4'b0000;
        n_cmp++; if (nmi !== 4'b0001) begin n_bad++; $display("FAIL ar_pre_nmi got=%b exp=%b", nmi, 4'b0001); end
        n_cmp++; if (pend !== 4'b0001) begin n_bad++; $display("FAIL ar_pre_pend got=%b exp=%b", pend, 4'b0001); end
        n_cmp++; if (err !== 4'b0110) begin n_bad++; $display("FAIL ar_pre_err got=%b exp=%b", err, 4'b0110); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL ar_nmi got=%b exp=%b", nmi, 4'b0000); end
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL ar_busy got=%b exp=%b", busy, 4'b0000); end
        n_cmp++; if (pend !== 4'b0000) begin n_bad++; $display("FAIL ar_pend got=%b exp=%b", pend, 4'b0000); end
        n_cmp++; if (err !== 4'b0000) begin n_bad++; $display("FAIL ar_err got=%b exp=%b", err, 4'b0000); end
        #2;
        rst_n = 1'b1;
        tick(2);
        wr_en = 1'b1; wr_mask = 4'b0001;
        tick(1);
        wr_en = 1'b0; wr_mask = 4'b0000;
        n_cmp++; if (nmi !== 4'b0001) begin n_bad++; $display("FAIL ar_post_nmi got=%b exp=%b", nmi, 4'b0001); end
        tick(2);
        n_cmp++; if (nmi !== 4'b0000) begin n_bad++; $display("FAIL ar_post_low got=%b exp=%b", nmi, 4'b0000); end
        ack = 4'b0001;
        tick(1);
        ack = 4'b0000;
        n_cmp++; if (busy !== 4'b0000) begin n_bad++; $display("FAIL ar_post_busy got=%b exp=%b", busy, 4'b0000); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_mask = 4'b0000; ack = 4'b0000; clr = 4'b0000;
        wr_en4 = 1'b0; wr_mask4 = 4'b0000; ack4 = 4'b0000; clr4 = 4'b0000;
        test_reset();
        test_single();
        test_timeout();
        test_back_to_back();
        test_early_ack();
        test_all_cpus();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_intc_nmi_gen
